// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states plus the request and
// response records that travel between the memory stage and storage.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and a registered read.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: accepts one request, waits WAIT_CYCLES, performs the
// array access, then presents a registered response until it is consumed.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] MAX_IDX   = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  state_t      r_state, w_state_next;
  mem_req_t    r_req, w_in_req, w_acc_req;
  mem_rsp_t    r_rsp;
  logic [3:0]  r_wait_cnt, w_wait_cnt_next;
  logic        r_rsp_valid, r_acc_pend, r_acc_load, r_acc_err;
  logic        w_accept, w_access, w_acc_err, w_arr_en;
  logic [31:0] w_arr_rdata;

  assign w_in_req  = '{we: i_req_we, addr: i_req_addr, wdata: i_req_wdata, be: i_req_be};
  assign w_accept  = i_req_valid && (r_state == IDLE) && !i_rst;
  // With no wait states the acceptance edge is also the access edge.
  assign w_acc_req = (r_state == IDLE) ? w_in_req : r_req;
  assign w_access  = (w_accept && NO_WAIT) || ((r_state == WAIT) && (r_wait_cnt == 4'd0));
  assign w_acc_err = (w_acc_req.addr[1:0] != 2'b00) || (w_acc_req.addr[31:2] >= MAX_IDX);
  assign w_arr_en  = w_access && !w_acc_err;

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_wait_cnt_next = WAIT_LOAD;
          if (NO_WAIT) w_state_next = RESP;
          else         w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_wait_cnt == 4'd0) w_state_next = RESP;
        else                    w_wait_cnt_next = r_wait_cnt - 4'd1;
      end
      RESP: begin
        if (r_rsp_valid && i_rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The array read lands one edge after the access, so the response
  // registers fill on that following edge while the FSM already sits in RESP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_wait_cnt  <= 4'd0;
      r_req       <= '0;
      r_acc_pend  <= 1'b0;
      r_acc_load  <= 1'b0;
      r_acc_err   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_acc_pend <= w_access;
      if (w_accept) r_req <= w_in_req;
      if (w_access) begin
        r_acc_err  <= w_acc_err;
        r_acc_load <= !w_acc_req.we && !w_acc_err;
      end
      if (r_acc_pend) begin
        r_rsp_valid <= 1'b1;
        r_rsp.rdata <= r_acc_load ? w_arr_rdata : 32'd0;
        r_rsp.err   <= r_acc_err;
      end else if (r_rsp_valid && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_rsp       <= '0;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_en    (w_arr_en),
    .i_we    (w_acc_req.we),
    .i_be    (w_acc_req.be),
    .i_addr  (w_acc_req.addr[AW+1:2]),
    .i_wdata (w_acc_req.wdata),
    .o_rdata (w_arr_rdata)
  );

  assign o_req_ready = (r_state == IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp.rdata;
  assign o_rsp_err   = r_rsp.err;

endmodule
